// File: rtl/shift_counter_pkg.sv
// Shared constants and types for the multimode shift counter.
//   MODE_JOHNSON / MODE_RING : values of the mode input
//   DIR_RIGHT / DIR_LEFT     : values of the dir input
//   action_e                 : next-state action chosen each cycle
package shift_counter_pkg;

  localparam logic MODE_JOHNSON = 1'b0;
  localparam logic MODE_RING    = 1'b1;
  localparam logic DIR_RIGHT    = 1'b0;
  localparam logic DIR_LEFT     = 1'b1;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  // Next-state action, listed in increasing priority.
  typedef enum logic [1:0] {
    ACT_HOLD = 2'd0,
    ACT_STEP = 2'd1,
    ACT_FIX  = 2'd2,
    ACT_LOAD = 2'd3
  } action_e;

endpackage

// File: rtl/shift_counter_decode.sv
// Combinational legality check and phase decode of the counter state.
// Ports:
//   q       in  WIDTH            current counter state
//   mode    in  1                0 = Johnson, 1 = ring
//   dir     in  1                0 = right shift, 1 = left shift
//   illegal out 1                q is outside the legal set for mode
//   phase   out clog2(2*WIDTH)   position of q in the current sequence
module shift_counter_decode
  import shift_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]               q,
  input  logic                           mode,
  input  logic                           dir,
  output logic                           illegal,
  output logic [$clog2(2*WIDTH)-1:0]     phase
);

  localparam int PW = $clog2(2*WIDTH);

  int   w_pop;
  int   w_trans;
  int   w_idx;
  int   w_phase;
  logic w_anchor;
  logic w_illegal;

  always_comb begin
    w_pop     = 0;
    w_trans   = 0;
    w_idx     = 0;
    w_phase   = 0;
    w_anchor  = 1'b0;
    w_illegal = 1'b0;

    for (int i = 0; i < WIDTH; i++) begin
      if (q[i]) begin
        w_pop = w_pop + 1;
        w_idx = i;
      end
    end

    // A Johnson thermometer has at most one 0/1 boundary inside the word:
    // all-zero, all-one, ones anchored at the MSB, or ones anchored at the LSB.
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (q[i] != q[i+1]) begin
        w_trans = w_trans + 1;
      end
    end

    if (mode == MODE_RING) begin
      w_illegal = (w_pop > 1);
    end else begin
      w_illegal = (w_trans > 1);
    end

    if (!w_illegal) begin
      if (mode == MODE_RING) begin
        if (w_pop == 0) begin
          w_phase = 0;
        end else if (dir == DIR_LEFT) begin
          w_phase = w_idx;
        end else begin
          w_phase = (WIDTH - w_idx) % WIDTH;
        end
      end else begin
        // The anchor bit is where new ones enter: set means we are in the
        // filling half of the cycle, clear means the draining half.
        w_anchor = (dir == DIR_RIGHT) ? q[WIDTH-1] : q[0];
        if (w_anchor || (w_pop == 0)) begin
          w_phase = w_pop;
        end else begin
          w_phase = 2 * WIDTH - w_pop;
        end
      end
    end

    illegal = w_illegal;
    phase   = PW'(w_phase);
  end

endmodule

// File: rtl/multimode_shift_counter.sv
// Johnson / ring shift counter with direction control, parallel load,
// self-correction of illegal states and a registered wrap pulse.
// Ports:
//   clk        in  1               rising-edge clock
//   reset      in  1               asynchronous active-high reset
//   en         in  1               step enable
//   load       in  1               synchronous load, overrides en
//   load_val   in  WIDTH           value captured on load
//   mode       in  1               0 = Johnson, 1 = ring
//   dir        in  1               0 = right shift, 1 = left shift
//   q          out WIDTH           registered counter state
//   phase      out clog2(2*WIDTH)  combinational position in sequence
//   wrap       out 1               registered pulse on return to phase 0
//   illegal    out 1               combinational, q illegal for mode
//   err_sticky out 1               set on any correction until reset
module multimode_shift_counter
  import shift_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       load,
  input  logic [WIDTH-1:0]           load_val,
  input  logic                       mode,
  input  logic                       dir,
  output logic [WIDTH-1:0]           q,
  output logic [$clog2(2*WIDTH)-1:0] phase,
  output logic                       wrap,
  output logic                       illegal,
  output logic                       err_sticky
);

  localparam int PW = $clog2(2*WIDTH);
  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic             r_err;

  logic [WIDTH-1:0] w_q_step;
  logic             w_fb;
  logic             w_illegal;
  logic [PW-1:0]    w_phase;
  logic [PW-1:0]    w_last_phase;
  action_e          w_act;

  shift_counter_decode #(
    .WIDTH (WIDTH)
  ) u_decode (
    .q       (r_q),
    .mode    (mode),
    .dir     (dir),
    .illegal (w_illegal),
    .phase   (w_phase)
  );

  always_comb begin
    w_fb = (dir == DIR_LEFT) ? r_q[WIDTH-1] : r_q[0];
    if (mode == MODE_JOHNSON) begin
      w_fb = ~w_fb;
    end

    // Ring idle (all-zero) is legal but has no bit to rotate; seed bit 0.
    if ((mode == MODE_RING) && (r_q == '0)) begin
      w_q_step = C_ONE;
    end else if (dir == DIR_LEFT) begin
      w_q_step = {r_q[WIDTH-2:0], w_fb};
    end else begin
      w_q_step = {w_fb, r_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    w_last_phase = (mode == MODE_RING) ? PW'(WIDTH - 1) : PW'(2 * WIDTH - 1);
  end

  always_comb begin
    if (load) begin
      w_act = ACT_LOAD;
    end else if (en && w_illegal) begin
      w_act = ACT_FIX;
    end else if (en) begin
      w_act = ACT_STEP;
    end else begin
      w_act = ACT_HOLD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      unique case (w_act)
        ACT_LOAD: begin
          r_q    <= load_val;
          r_wrap <= 1'b0;
        end
        ACT_FIX: begin
          r_q    <= '0;
          r_wrap <= 1'b0;
          r_err  <= 1'b1;
        end
        ACT_STEP: begin
          r_q    <= w_q_step;
          // A legal step from the last phase always lands on phase 0.
          r_wrap <= (w_phase == w_last_phase);
        end
        ACT_HOLD: begin
          r_wrap <= 1'b0;
        end
        default: begin
          r_wrap <= 1'b0;
        end
      endcase
    end
  end

  assign q          = r_q;
  assign wrap       = r_wrap;
  assign err_sticky = r_err;
  assign illegal    = w_illegal;
  assign phase      = w_phase;

endmodule

// File: tb/tb_multimode_shift_counter.sv
module tb_multimode_shift_counter;

  localparam int N = 4;

  logic       clk;
  logic       reset;
  logic       en;
  logic       load;
  logic [3:0] load_val;
  logic       mode;
  logic       dir;
  logic [3:0] q;
  logic [2:0] phase;
  logic       wrap;
  logic       illegal;
  logic       err_sticky;

  int errors = 0;
  int checks = 0;

  logic [3:0] m_q;
  logic       m_wrap;
  logic       m_err;

  logic [3:0] exp_j [8];
  logic [3:0] exp_r [5];

  multimode_shift_counter #(.WIDTH(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .load       (load),
    .load_val   (load_val),
    .mode       (mode),
    .dir        (dir),
    .q          (q),
    .phase      (phase),
    .wrap       (wrap),
    .illegal    (illegal),
    .err_sticky (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Pattern shown at position k of the sequence for a given mode/dir.
  function automatic logic [3:0] pat(input int k, input logic md, input logic dr);
    logic [3:0] p;
    int ones;
    logic top;
    p = 4'b0000;
    if (md) begin
      if (dr) p[k] = 1'b1;
      else    p[(N - k) % N] = 1'b1;
    end else begin
      ones = (k <= N) ? k : 2 * N - k;
      top  = (k <= N) ^ dr;
      for (int i = 0; i < ones; i++) begin
        if (top) p[N-1-i] = 1'b1;
        else     p[i] = 1'b1;
      end
    end
    return p;
  endfunction

  // Position of v in the sequence, -1 if it is not in the legal set.
  function automatic int find_k(input logic [3:0] v, input logic md, input logic dr);
    int per;
    per = md ? N : 2 * N;
    if (md && v == 4'b0000) return 0;
    for (int k = 0; k < per; k++) begin
      if (pat(k, md, dr) == v) return k;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int k;
    k = find_k(m_q, mode, dir);
    chk({tag, "_q"},       32'(q),          32'(m_q));
    chk({tag, "_wrap"},    32'(wrap),       32'(m_wrap));
    chk({tag, "_err"},     32'(err_sticky), 32'(m_err));
    chk({tag, "_illegal"}, 32'(illegal),    32'(k < 0));
    chk({tag, "_phase"},   32'(phase),      (k < 0) ? 32'd0 : 32'(k));
  endtask

  task automatic step(input logic e, input logic ld, input logic [3:0] lv,
                      input logic md, input logic dr, input string tag);
    int k;
    int per;
    @(negedge clk);
    en = e; load = ld; load_val = lv; mode = md; dir = dr;
    per = md ? N : 2 * N;
    k = find_k(m_q, md, dr);
    if (ld) begin
      m_q = lv; m_wrap = 1'b0;
    end else if (e && k < 0) begin
      m_q = 4'b0000; m_err = 1'b1; m_wrap = 1'b0;
    end else if (e) begin
      if (md && m_q == 4'b0000) begin
        m_q = 4'b0001; m_wrap = 1'b0;
      end else begin
        m_wrap = (k == per - 1);
        m_q = pat((k + 1) % per, md, dr);
      end
    end else begin
      m_wrap = 1'b0;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Asserts reset half-way between edges and checks it acts without a clock.
  task automatic do_reset(input string tag);
    @(negedge clk);
    en = 1'b0; load = 1'b0;
    reset = 1'b1;
    #1;
    m_q = 4'b0000; m_wrap = 1'b0; m_err = 1'b0;
    chk({tag, "_q"},    32'(q),          32'd0);
    chk({tag, "_wrap"}, 32'(wrap),       32'd0);
    chk({tag, "_err"},  32'(err_sticky), 32'd0);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    logic e, ld, md, dr;
    logic [3:0] lv;

    exp_j = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
    exp_r = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    reset = 1'b1; en = 1'b0; load = 1'b0; load_val = 4'b0000; mode = 1'b0; dir = 1'b0;
    m_q = 4'b0000; m_wrap = 1'b0; m_err = 1'b0;
    #12;
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    chk("rst_err", 32'(err_sticky), 32'd0);
    reset = 1'b0;

    // Johnson right shift, full cycle from reset.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, "john_r");
      chk("john_r_lit_q", 32'(q), 32'(exp_j[i]));
      chk("john_r_lit_phase", 32'(phase), 32'((i + 1) % 8));
      chk("john_r_lit_wrap", 32'(wrap), 32'(i == 7));
    end

    // Ring left shift from idle.
    do_reset("rst_a");
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, "ring_l");
      chk("ring_l_lit_q", 32'(q), 32'(exp_r[i]));
      chk("ring_l_lit_wrap", 32'(wrap), 32'(i == 4));
    end

    // Illegal load in Johnson, then correction.
    do_reset("rst_b");
    step(1'b0, 1'b1, 4'b0101, 1'b0, 1'b0, "ld_ill");
    chk("ld_ill_lit_illegal", 32'(illegal), 32'd1);
    chk("ld_ill_lit_phase", 32'(phase), 32'd0);
    step(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, "fix");
    chk("fix_lit_q", 32'(q), 32'd0);
    chk("fix_lit_err", 32'(err_sticky), 32'd1);
    chk("fix_lit_wrap", 32'(wrap), 32'd0);
    step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, "hold");
    chk("hold_lit_err", 32'(err_sticky), 32'd1);

    // Direction switch mid-sequence.
    do_reset("rst_c");
    step(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, "dsw0");
    step(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, "dsw1");
    step(1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, "dsw2");
    chk("dsw_lit_q", 32'(q), 32'(4'b1000));

    // Async reset mid-sequence, restart from zero, load beats enable.
    do_reset("rst_d");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, "pre");
    chk("pre_lit_q", 32'(q), 32'(4'b1110));
    do_reset("async");
    step(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, "restart");
    chk("restart_lit_q", 32'(q), 32'(4'b1000));
    step(1'b1, 1'b1, 4'b1010, 1'b0, 1'b0, "ld_en");
    chk("ld_en_lit_q", 32'(q), 32'(4'b1010));

    // Ring at 0000 with en=0: phase must be 0, not illegal.
    do_reset("rst_e");
    step(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, "ring_idle");

    // Randomized traffic against the reference model.
    md = 1'b0; dr = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        do_reset("rnd_rst");
      end else begin
        e  = ($urandom_range(0, 99) < 75);
        ld = ($urandom_range(0, 99) < 8);
        lv = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 99) < 10) md = ~md;
        if ($urandom_range(0, 99) < 10) dr = ~dr;
        step(e, ld, lv, md, dr, "rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multimode_shift_counter.md
MULTIMODE_SHIFT_COUNTER -- requirements
Module: multimode_shift_counter

Interface
REQ-001 SHALL have parameter: WIDTH, 4, register length N (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: en  input  1  step enable.
REQ-005 SHALL have port: load  input  1  synchronous parallel load; has priority over en.
REQ-006 SHALL have port: load_val  input  WIDTH  value captured on load.
REQ-007 SHALL have port: mode  input  1  0 = Johnson (inverted feedback), 1 = ring (direct feedback).
REQ-008 SHALL have port: dir  input  1  0 = right shift (feed into MSB), 1 = left shift (feed into LSB).
REQ-009 SHALL have port: q  output  WIDTH  counter state (registered).
REQ-010 SHALL have port: phase  output  $clog2(2*WIDTH)  position in current sequence (combinational from q, mode, dir).
REQ-011 SHALL have port: wrap  output  1  registered one-cycle pulse on return to phase 0.
REQ-012 SHALL have port: illegal  output  1  combinational; q not in legal set for current mode.
REQ-013 SHALL have port: err_sticky  output  1  registered; set on any correction, cleared only by reset.

Function
REQ-014 Next-state priority SHALL be: load > en-with-illegal-q (correction) > en (step) > hold.
REQ-015 Johnson step SHALL be: dir=0 q <= {~q[0], q[N-1:1]}; dir=1 q <= {q[N-2:0], ~q[N-1]}.
REQ-016 Ring step SHALL be: dir=0 q <= {q[0], q[N-1:1]}; dir=1 q <= {q[N-2:0], q[N-1]}; an enabled step from all-zero SHALL give q=1 (bit 0 set), with wrap=0.
REQ-017 Legal sets SHALL be: Johnson = 2N contiguous-ones thermometer patterns reachable from zero (for either dir); ring = one-hot patterns plus all-zero (idle).
REQ-018 Correction SHALL be: enabled edge with illegal=1 sets q <= 0 and err_sticky <= 1, with wrap=0.
REQ-019 Load SHALL take load_val verbatim, even if illegal, with wrap=0; legality is evaluated on the following cycles.
REQ-020 Johnson phase SHALL be: dir=0 -> popcount(q) if q[N-1]=1 or q=0, else 2N-popcount(q); dir=1 -> same rule using q[0] in place of q[N-1].
REQ-021 Ring phase SHALL be: dir=1 -> index of set bit; dir=0 -> (N-index) mod N; idle -> 0.
REQ-022 phase SHALL be 0 whenever illegal=1.
REQ-023 wrap SHALL assert in the same cycle that q first shows phase 0 after an enabled step from phase 2N-1 (Johnson) or N-1 (ring), and only then.
REQ-024 mode/dir changes SHALL take effect on the next edge with no pipeline; a q illegal under the new mode SHALL be corrected per REQ-018.
REQ-025 With en=0 and load=0, q and err_sticky SHALL hold and wrap SHALL be 0.

Reset
REQ-026 reset=1 SHALL force q=0, wrap=0 and err_sticky=0 immediately, independent of clk.
REQ-027 Reset mid-sequence SHALL discard the current state; the first enabled edge after release SHALL step from zero.

Structure
REQ-028 Package shift_counter_pkg SHALL hold MODE_JOHNSON=0, MODE_RING=1, DIR_RIGHT=0 and DIR_LEFT=1.
REQ-029 One combinational sub-module, shift_counter_decode, SHALL compute illegal and phase from q, mode and dir.

Verification (WIDTH=4)
REQ-030 Johnson, dir=0, en=1, 8 edges from reset -> q 1000,1100,1110,1111,0111,0011,0001,0000; phase 1..7,0; wrap=1 only after the 8th edge.
REQ-031 Ring, dir=1, en=1 from reset -> q 0001,0010,0100,1000,0001; wrap=0 on the first step and wrap=1 on the return to 0001.
REQ-032 Johnson, load=1 with load_val=0101, then en=1 -> illegal=1, phase=0; next edge q=0000, err_sticky=1, wrap=0.
REQ-033 Johnson at q=1100, dir switched to 1, one enabled edge -> q=1000.
REQ-034 Async reset asserted between edges with q=1110 -> q=0000 before the next clk edge; load and en both high -> load_val captured.
